// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the execute stage
// Single-cycle registered multiply, 32-step restoring divide, special cases resolved at accept.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [5:0]       count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic             neg_q;
    logic             neg_r;

    // Accept-time decode of the incoming divide operands
    logic             is_signed_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        is_signed_div = ~funct3[0];
        a_neg         = is_signed_div & a[WIDTH-1];
        b_neg         = is_signed_div & b[WIDTH-1];
        a_mag         = a_neg ? (~a + 1'b1) : a;
        b_mag         = b_neg ? (~b + 1'b1) : b;
        div_zero      = (b == '0);
        div_ovf       = is_signed_div && (a == MIN_INT) && (b == '1);
        special_res   = '0;
        if (div_zero)
            special_res = funct3[1] ? a : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : MIN_INT;
    end

    // Operands sign- or zero-extended so one signed multiplier covers all four variants
    logic                     a_sgn;
    logic                     b_sgn;
    logic signed [2*WIDTH-1:0] mul_a;
    logic signed [2*WIDTH-1:0] mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          mul_res;

    always_comb begin
        a_sgn   = op[0] ^ op[1];
        b_sgn   = (op == 2'b01);
        mul_a   = {{WIDTH{a_sgn & opa[WIDTH-1]}}, opa};
        mul_b   = {{WIDTH{b_sgn & opb[WIDTH-1]}}, opb};
        prod    = mul_a * mul_b;
        mul_res = (op == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    // One restoring step; the extra top bit of diff is the borrow
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quot_n;
    logic [WIDTH-1:0] div_res;

    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        take    = ~diff[WIDTH];
        rem_n   = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_n  = {quot[WIDTH-2:0], take};
        if (op[1])
            div_res = neg_r ? (~rem_n + 1'b1) : rem_n;
        else
            div_res = neg_q ? (~quot_n + 1'b1) : quot_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            count   <= '0;
            op      <= '0;
            opa     <= '0;
            opb     <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        op      <= funct3[1:0];
                        opa     <= a;
                        opb     <= b;
                        rem     <= '0;
                        quot    <= a_mag;
                        divisor <= b_mag;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        count   <= '0;
                        if (!funct3[2]) begin
                            state <= S_MUL;
                            busy  <= 1'b1;
                        end else if (div_zero || div_ovf) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= special_res;
                        end else begin
                            state <= S_DIV;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    state  <= S_DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= mul_res;
                end
                S_DIV: begin
                    rem   <= rem_n;
                    quot  <= quot_n;
                    count <= count + 6'd1;
                    if (count == LAST_ITER) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= div_res;
                        count  <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
